// File: rtl/spine_pkg.sv
// Shared constants and types for the group spine router.
// Defines port counts, flit width, port-index ranges and the arbiter state enum.
package spine_pkg;

   localparam int NUM_SPINE_PORTS = 11;
   localparam int SPINE_DWIDTH    = 16;

   // Leaf ports come first, group ports follow.
   localparam int LEAF_PORT_FIRST  = 0;
   localparam int LEAF_PORT_LAST   = 3;
   localparam int GROUP_PORT_FIRST = 4;
   localparam int GROUP_PORT_LAST  = 10;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

endpackage

// File: rtl/spine_port_arbiter_if.sv
// Input-FIFO / output-FIFO bundle shared between an output arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the driving environment.
interface spine_port_arbiter_if
   import spine_pkg::*;
#(
   parameter int NUM_PORTS = NUM_SPINE_PORTS,
   parameter int DWIDTH    = SPINE_DWIDTH
);
   localparam int IW = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0]        req;
   logic [NUM_PORTS-1:0]        in_mask;
   logic [NUM_PORTS*DWIDTH-1:0] in_data;
   logic                        out_fifo_full;
   logic [NUM_PORTS-1:0]        pop;
   logic [NUM_PORTS-1:0]        gnt;
   logic [IW-1:0]               gnt_idx;
   logic [DWIDTH-1:0]           out_data;
   logic                        out_valid;

   modport slave (
      input  req, in_mask, in_data, out_fifo_full,
      output pop, gnt, gnt_idx, out_data, out_valid
   );

   modport master (
      output req, in_mask, in_data, out_fifo_full,
      input  pop, gnt, gnt_idx, out_data, out_valid
   );

endinterface

// File: rtl/spine_port_arbiter_rr_pick.sv
// Circular priority encoder: first set request at or above i_start, wrapping to 0.
// Purely combinational; outputs are zero when no request is set.
module rr_pick #(
   parameter int N  = 11,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_start,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx
);

   int w_pos;

   // NOTE: every output gets a default before the search so no path can infer a latch.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      w_pos    = 0;
      // Scan farthest offset first so the nearest hit is the one that sticks.
      for (int off = N - 1; off >= 0; off--) begin
         w_pos = int'(i_start) + off;
         if (w_pos >= N) w_pos = w_pos - N;
         if (i_req[w_pos]) begin
            o_onehot        = '0;
            o_onehot[w_pos] = 1'b1;
            o_idx           = IW'(w_pos);
         end
      end
   end

endmodule

// File: rtl/spine_port_arbiter.sv
// Round-robin output-port arbiter and registered flit mux for one spine output FIFO.
// Grants one input for up to MAX_BURST flits, then rotates the priority pointer.
module spine_port_arbiter
   import spine_pkg::*;
#(
   parameter int NUM_PORTS = NUM_SPINE_PORTS,
   parameter int DWIDTH    = SPINE_DWIDTH,
   parameter int MAX_BURST = 4
) (
   input logic                 clk,
   input logic                 reset,
   spine_port_arbiter_if.slave bus
);

   localparam int              IW        = $clog2(NUM_PORTS);
   localparam int              CW        = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0]   LAST_BEAT = CW'(MAX_BURST - 1);
   localparam logic [IW-1:0]   LAST_PORT = IW'(NUM_PORTS - 1);

   arb_state_t           r_state, w_next_state;
   logic [NUM_PORTS-1:0] r_gnt;
   logic [IW-1:0]        r_gnt_idx;
   logic [IW-1:0]        r_rr_ptr;
   logic [CW-1:0]        r_burst_cnt;
   logic                 r_out_valid;
   logic [DWIDTH-1:0]    r_out_data;

   logic [NUM_PORTS-1:0] w_ereq;
   logic [NUM_PORTS-1:0] w_pick_onehot;
   logic [IW-1:0]        w_pick_idx;
   logic [DWIDTH-1:0]    w_head;
   logic                 w_xfer;
   logic                 w_exit;

   assign w_ereq = bus.req & bus.in_mask;
   assign w_head = bus.in_data[int'(r_gnt_idx)*DWIDTH +: DWIDTH];

   rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
      .i_req    (w_ereq),
      .i_start  (r_rr_ptr),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx)
   );

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_xfer       = 1'b0;
      w_exit       = 1'b0;
      case (r_state)
         IDLE: begin
            if (|w_ereq) w_next_state = BURST;
         end
         BURST: begin
            // A full output FIFO stalls the burst but never ends it.
            w_xfer = w_ereq[r_gnt_idx] & ~bus.out_fifo_full;
            w_exit = ~w_ereq[r_gnt_idx] | (w_xfer & (r_burst_cnt == LAST_BEAT));
            if (w_exit) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_gnt       <= '0;
         r_gnt_idx   <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_out_valid <= w_xfer;
         if (w_xfer) r_out_data <= w_head;

         if (r_state == IDLE) begin
            if (|w_ereq) begin
               r_gnt       <= w_pick_onehot;
               r_gnt_idx   <= w_pick_idx;
               r_burst_cnt <= '0;
            end
         end else if (w_exit) begin
            r_rr_ptr  <= (r_gnt_idx == LAST_PORT) ? '0 : r_gnt_idx + IW'(1);
            r_gnt     <= '0;
            r_gnt_idx <= '0;
         end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
         end
      end
   end

   assign bus.pop       = w_xfer ? r_gnt : '0;
   assign bus.gnt       = r_gnt;
   assign bus.gnt_idx   = r_gnt_idx;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_spine_port_arbiter.sv
// Self-checking bench for spine_port_arbiter: directed scenarios with literal
// expectations plus a randomized run, all compared against a flit-level model.
module tb_spine_port_arbiter;
   import spine_pkg::*;

   localparam int N  = NUM_SPINE_PORTS;
   localparam int DW = SPINE_DWIDTH;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;

   spine_port_arbiter_if #(.NUM_PORTS(N), .DWIDTH(DW)) bus ();

   spine_port_arbiter #(.NUM_PORTS(N), .DWIDTH(DW), .MAX_BURST(MB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: which port owns the output (-1 = none), flits moved in this grant,
   // where the next search starts, and what the output register holds.
   int              m_owner = -1;
   int              m_flits = 0;
   int              m_ptr   = 0;
   bit              m_valid = 1'b0;
   logic [DW-1:0]   m_data  = '0;
   logic [N-1:0]    m_ereq;
   logic [N-1:0]    e_gnt, e_pop;
   bit              m_moved;

   always @(negedge clk) begin
      m_ereq  = bus.req & bus.in_mask;
      m_moved = (m_owner >= 0) && m_ereq[m_owner] && !bus.out_fifo_full;
      e_gnt   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_pop   = m_moved ? e_gnt : '0;
      if (chk_en) begin
         check("gnt",       32'(bus.gnt),       32'(e_gnt));
         check("gnt_idx",   32'(bus.gnt_idx),   (m_owner >= 0) ? m_owner : 0);
         check("pop",       32'(bus.pop),       32'(e_pop));
         check("out_valid", 32'(bus.out_valid), 32'(m_valid));
         check("out_data",  32'(bus.out_data),  32'(m_data));
      end
      if (reset) begin
         m_owner = -1; m_flits = 0; m_ptr = 0; m_valid = 1'b0; m_data = '0;
      end else begin
         m_valid = m_moved;
         if (m_moved) m_data = bus.in_data[m_owner*DW +: DW];
         if (m_owner < 0) begin
            for (int k = N - 1; k >= 0; k--)
               if (m_ereq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            m_flits = 0;
         end else begin
            if (m_moved) m_flits++;
            if (!m_ereq[m_owner] || (m_moved && m_flits == MB)) begin
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
            end
         end
      end
   end

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = DW'($urandom);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req = '0;
      bus.in_mask = '1;
      bus.out_fifo_full = 1'b0;
      adv();
      adv();
      reset = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.req = '0;
      bus.in_mask = '1;
      bus.in_data = '0;
      bus.out_fifo_full = 1'b0;
      do_reset();
      chk_en = 1'b1;

      // Single requester on port 0
      bus.in_data[0*DW +: DW] = 16'hA5A5;
      bus.req = 11'h001;
      mid(); check("single_c0_gnt", bus.gnt, 32'h0);
      adv(); mid(); check("single_c1_gnt", bus.gnt, 32'h001);
                    check("single_c1_pop", bus.pop, 32'h001);
      adv(); mid(); check("single_c2_valid", bus.out_valid, 32'h1);
                    check("single_c2_data", bus.out_data, 32'hA5A5);
      adv(); adv();
      mid(); check("single_c4_pop", bus.pop, 32'h001);
      adv(); mid(); check("single_c5_gnt", bus.gnt, 32'h0);
                    check("single_c5_valid", bus.out_valid, 32'h1);
      adv(); mid(); check("single_c6_regrant", bus.gnt, 32'h001);
      adv();

      // Full contention rotation
      do_reset();
      bus.req = 11'h7FF;
      for (int c = 0; c <= 57; c++) begin
         rand_data();
         mid();
         if (c == 6)  check("rot_c6_idx", bus.gnt_idx, 32'd1);
         if (c == 51) check("rot_c51_idx", bus.gnt_idx, 32'd10);
         if (c == 56) check("rot_c56_wrap", bus.gnt, 32'h001);
         adv();
      end

      // Backpressure on port 3
      do_reset();
      bus.in_data[3*DW +: DW] = 16'h3333;
      bus.req = 11'h008;
      adv(); adv();
      bus.out_fifo_full = 1'b1;
      mid(); check("bp_c2_gnt", bus.gnt, 32'h008);
             check("bp_c2_pop", bus.pop, 32'h0);
      adv(); mid(); check("bp_c3_valid", bus.out_valid, 32'h0);
      adv(); adv();
      bus.out_fifo_full = 1'b0;
      mid(); check("bp_c5_pop", bus.pop, 32'h008);
      adv(); adv(); mid(); check("bp_c7_pop", bus.pop, 32'h008);
      adv(); mid(); check("bp_c8_gnt", bus.gnt, 32'h0);
      adv();

      // Early drop of port 5, then pointer must sit at 6
      do_reset();
      bus.req = 11'h020;
      adv(); adv(); mid(); check("drop_c2_pop", bus.pop, 32'h020);
      adv();
      bus.req = '0;
      mid(); check("drop_c3_pop", bus.pop, 32'h0);
      adv();
      bus.req = 11'h070;
      mid(); check("drop_c4_gnt", bus.gnt, 32'h0);
      adv(); mid(); check("drop_c5_ptr6", bus.gnt, 32'h040);
      adv();

      // Masked port never granted
      do_reset();
      bus.in_mask = 11'h7DF;
      bus.req = 11'h020;
      for (int c = 0; c < 20; c++) begin
         mid();
         if (c == 19) check("mask_no_grant", bus.gnt, 32'h0);
         adv();
      end

      // Reset during port 7's second flit
      do_reset();
      bus.in_data[7*DW +: DW] = 16'h1234;
      bus.req = 11'h080;
      adv(); adv();
      reset = 1'b1;
      mid(); check("rst_c2_pop", bus.pop, 32'h080);
      adv();
      reset = 1'b0;
      bus.req = 11'h081;
      mid(); check("rst_c3_gnt", bus.gnt, 32'h0);
             check("rst_c3_valid", bus.out_valid, 32'h0);
             check("rst_c3_data", bus.out_data, 32'h0);
      adv(); mid(); check("rst_c4_port0", bus.gnt, 32'h001);
      adv();

      // Randomized traffic with sticky requests, sparse masking, stalls and resets
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rand_data();
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(9) == 0) bus.req[i] = ~bus.req[i];
            bus.in_mask[i] = ($urandom_range(31) != 0);
         end
         bus.out_fifo_full = ($urandom_range(4) == 0);
         reset = ($urandom_range(199) == 0);
         adv();
      end
      reset = 1'b0;
      mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
